// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of a single-port asynchronous-read SRAM; one access every three cycles.
// Define SRAM_ARB_RR_EN for round-robin on ties; otherwise port 0 has fixed priority.
module sram_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  output logic              sram_we,
  input  logic [DATA_W-1:0] sram_dout
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  state_t            state, state_nx;
  logic              sel, sel_nx;
  logic              pick1;
  logic              we_nx, gnt0_nx, gnt1_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [DATA_W-1:0] din_nx, rdata0_nx, rdata1_nx;
`ifdef SRAM_ARB_RR_EN
  logic              last, last_nx;
`endif

  // Next-state and next-output logic; outputs are all registered below.
  always_comb begin
    state_nx  = state;
    sel_nx    = sel;
    we_nx     = 1'b0;
    addr_nx   = sram_addr;
    din_nx    = sram_din;
    gnt0_nx   = 1'b0;
    gnt1_nx   = 1'b0;
    rdata0_nx = rdata0;
    rdata1_nx = rdata1;
`ifdef SRAM_ARB_RR_EN
    last_nx   = last;
    // last==0 means port 0 was granted most recently, so port 1 wins a tie
    pick1     = req1 & (~req0 | ~last);
`else
    pick1     = req1 & ~req0;
`endif
    case (state)
      IDLE: begin
        if (req0 | req1) begin
          sel_nx   = pick1;
          we_nx    = pick1 ? we1 : we0;
          addr_nx  = pick1 ? addr1 : addr0;
          din_nx   = pick1 ? wdata1 : wdata0;
          state_nx = ACCESS;
`ifdef SRAM_ARB_RR_EN
          last_nx  = pick1;
`endif
        end
      end
      ACCESS: begin
        // The SRAM commits a write at the edge leaving ACCESS; reads are captured here too
        if (sel) begin
          gnt1_nx = 1'b1;
          if (!sram_we) rdata1_nx = sram_dout;
        end else begin
          gnt0_nx = 1'b1;
          if (!sram_we) rdata0_nx = sram_dout;
        end
        state_nx = ACK;
      end
      ACK: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sel       <= 1'b0;
      sram_we   <= 1'b0;
      sram_addr <= '0;
      sram_din  <= '0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
`ifdef SRAM_ARB_RR_EN
      last      <= 1'b1;
`endif
    end else begin
      state     <= state_nx;
      sel       <= sel_nx;
      sram_we   <= we_nx;
      sram_addr <= addr_nx;
      sram_din  <= din_nx;
      gnt0      <= gnt0_nx;
      gnt1      <= gnt1_nx;
      rdata0    <= rdata0_nx;
      rdata1    <= rdata1_nx;
`ifdef SRAM_ARB_RR_EN
      last      <= last_nx;
`endif
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter with a behavioural asynchronous-read SRAM attached.
// Expectations follow the fixed-priority build unless SRAM_ARB_RR_EN is defined.
module tb_sram_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1, we0, we1;
  logic [3:0] addr0, addr1, sram_addr;
  logic [7:0] wdata0, wdata1, rdata0, rdata1, sram_din, sram_dout;
  logic       gnt0, gnt1, sram_we;

  logic [7:0] mem [16];
  logic [7:0] exp_mem [16];
  logic [7:0] mrd0, mrd1;
  logic [7:0] sweep_data [16];

  typedef struct {
    bit         port;
    logic [7:0] rd0;
    logic [7:0] rd1;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad = 0;
  int we_cycles = 0;
  int writes_issued = 0;

  sram_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rdata0(rdata0), .rdata1(rdata1),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_we(sram_we),
    .sram_dout(sram_dout)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: synchronous write on registered sram_we, asynchronous read
  always @(posedge clk) if (sram_we) mem[sram_addr] <= sram_din;
  assign sram_dout = mem[sram_addr];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Update the small reference model and queue the response the monitor should see
  task automatic pushExp(input bit port, input bit is_wr, input logic [3:0] a, input logic [7:0] d);
    exp_t e;
    if (is_wr) begin
      exp_mem[a] = d;
      writes_issued++;
    end else if (port) mrd1 = exp_mem[a];
    else mrd0 = exp_mem[a];
    e.port = port;
    e.rd0  = mrd0;
    e.rd1  = mrd1;
    sb.push_back(e);
  endtask

  // Monitor: pops the scoreboard on every grant, independent of the stimulus
  always @(negedge clk) begin
    exp_t e;
    if (sram_we) we_cycles++;
    if (gnt0 && gnt1) begin
      total++;
      bad++;
      $display("[TB] FAIL gnt_overlap: got gnt0=%0b gnt1=%0b expected one-hot", gnt0, gnt1);
    end else if (gnt0 || gnt1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_gnt: got gnt1=%0b expected no grant", gnt1);
      end else begin
        e = sb.pop_front();
        checkOutput("gnt_port", {31'd0, gnt1}, {31'd0, e.port});
        checkOutput("rdata0", {24'd0, rdata0}, {24'd0, e.rd0});
        checkOutput("rdata1", {24'd0, rdata1}, {24'd0, e.rd1});
      end
    end
  end

  // Drive one or both ports, drop each req at its grant, report grant latencies
  task automatic applyStimulus(input bit r0, input bit w0v, input logic [3:0] a0v, input logic [7:0] d0v,
                               input bit r1, input bit w1v, input logic [3:0] a1v, input logic [7:0] d1v,
                               output int lat0, output int lat1);
    bit p0, p1;
    int cyc;
    @(negedge clk);
    req0 = r0; we0 = w0v; addr0 = a0v; wdata0 = d0v;
    req1 = r1; we1 = w1v; addr1 = a1v; wdata1 = d1v;
    p0 = r0; p1 = r1; cyc = 0; lat0 = -1; lat1 = -1;
    while ((p0 || p1) && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (p0 && gnt0) begin p0 = 0; req0 = 0; lat0 = cyc; end
      if (p1 && gnt1) begin p1 = 0; req1 = 0; lat1 = cyc; end
    end
    if (p0 || p1) begin
      total++;
      bad++;
      $display("[TB] FAIL grant_timeout: got pending=%0b%0b expected 00", p1, p0);
      req0 = 0; req1 = 0;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int l0, l1, g0, g1;
    for (int i = 0; i < 16; i++) begin mem[i] = 8'h00; exp_mem[i] = 8'h00; end
    mrd0 = 0; mrd1 = 0;
    reset = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    repeat (2) @(negedge clk);
    checkOutput("reset_outputs", {gnt0, gnt1, sram_we, sram_addr, sram_din, rdata0, rdata1},
                {3'b000, 4'h0, 8'h00, 8'h00, 8'h00});
    reset = 0;

    // Simultaneous writes: port 0 wins the first tie in both builds
    pushExp(0, 1, 4'd1, 8'h11);
    pushExp(1, 1, 4'd2, 8'h22);
    applyStimulus(1, 1, 4'd1, 8'h11, 1, 1, 4'd2, 8'h22, l0, l1);
    checkOutput("tie_lat0", l0, 2);
    checkOutput("tie_lat1", l1, 5);

    // Continuous contention on reads of addr 1 / addr 2
`ifdef SRAM_ARB_RR_EN
    pushExp(0, 0, 4'd1, 0); pushExp(1, 0, 4'd2, 0);
    pushExp(0, 0, 4'd1, 0); pushExp(1, 0, 4'd2, 0);
`else
    for (int i = 0; i < 4; i++) pushExp(0, 0, 4'd1, 0);
`endif
    @(negedge clk);
    req0 = 1; we0 = 0; addr0 = 4'd1; req1 = 1; we1 = 0; addr1 = 4'd2;
    g0 = 0; g1 = 0;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      if (gnt0) g0++;
      if (gnt1) g1++;
    end
    req0 = 0; req1 = 0;
    repeat (4) @(negedge clk);
`ifdef SRAM_ARB_RR_EN
    checkOutput("contend_g0", g0, 2);
    checkOutput("contend_g1", g1, 2);
`else
    checkOutput("contend_g0", g0, 4);
    checkOutput("contend_g1", g1, 0);
`endif

    // Single write then read on port 0
    pushExp(0, 1, 4'd3, 8'hA5);
    applyStimulus(1, 1, 4'd3, 8'hA5, 0, 0, 0, 0, l0, l1);
    checkOutput("wr_lat0", l0, 2);
    pushExp(0, 0, 4'd3, 0);
    applyStimulus(1, 0, 4'd3, 8'h00, 0, 0, 0, 0, l0, l1);
    checkOutput("rd_lat0", l0, 2);
    checkOutput("rd_A5", {24'd0, rdata0}, 32'hA5);

    // Cross-port data: port 1 writes, port 0 reads
    pushExp(1, 1, 4'd15, 8'h3C);
    applyStimulus(0, 0, 0, 0, 1, 1, 4'd15, 8'h3C, l0, l1);
    checkOutput("wr_lat1", l1, 2);
    pushExp(0, 0, 4'd15, 0);
    applyStimulus(1, 0, 4'd15, 8'h00, 0, 0, 0, 0, l0, l1);
    checkOutput("cross_3C", {24'd0, rdata0}, 32'h3C);

    // Reset during ACCESS of a write: write lands, no grant, outputs reset
    @(negedge clk);
    req0 = 1; we0 = 1; addr0 = 4'd5; wdata0 = 8'h77;
    @(negedge clk);
    checkOutput("mid_access_we", {31'd0, sram_we}, 32'd1);
    reset = 1;
    @(negedge clk);
    checkOutput("mid_reset_outputs", {gnt0, gnt1, sram_we, sram_addr, sram_din, rdata0, rdata1},
                {3'b000, 4'h0, 8'h00, 8'h00, 8'h00});
    reset = 0; req0 = 0;
    exp_mem[5] = 8'h77; writes_issued++;
    mrd0 = 0; mrd1 = 0;
    repeat (4) @(negedge clk);
    pushExp(1, 0, 4'd5, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 4'd5, 8'h00, l0, l1);
    checkOutput("after_reset_77", {24'd0, rdata1}, 32'h77);

    // Full sweep: random writes alternating ports, then read everything back
    for (int i = 0; i < 16; i++) begin
      sweep_data[i] = 8'($urandom_range(0, 255));
      pushExp(i[0], 1, 4'(i), sweep_data[i]);
      if (i[0]) applyStimulus(0, 0, 0, 0, 1, 1, 4'(i), sweep_data[i], l0, l1);
      else      applyStimulus(1, 1, 4'(i), sweep_data[i], 0, 0, 0, 0, l0, l1);
    end
    for (int i = 0; i < 16; i++) begin
      pushExp(~i[0], 0, 4'(i), 0);
      if (i[0]) applyStimulus(1, 0, 4'(i), 8'h00, 0, 0, 0, 0, l0, l1);
      else      applyStimulus(0, 0, 0, 0, 1, 0, 4'(i), 8'h00, l0, l1);
      checkOutput("sweep_data", {24'd0, (i[0] ? rdata0 : rdata1)}, {24'd0, sweep_data[i]});
    end

    repeat (4) @(negedge clk);
    checkOutput("we_cycles", we_cycles, writes_issued);
    checkOutput("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
